// File: rtl/sseg_scan_driver.sv
// Multiplexed hex seven-segment scan driver.
// A prescaler paces a digit index across NUM_DIGITS anodes. New images are
// double-buffered (pending -> displayed) and only swapped at a frame wrap.
// This prevents a frame from mixing old and new digits.
// On each tick the registered outputs show digit idx from the displayed image.
// A commit on the wrap tick therefore first appears on the following digit 0.
module sseg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  output logic [6:0]                sseg,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);
  localparam logic          AL   = (ACTIVE_LOW != 0);
  localparam logic [6:0]    SEG_OFF = AL ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AL}};

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [PW-1:0]               presc_q, presc_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]     pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]       pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]       pend_en_q, pend_en_d, disp_en_q, disp_en_d;
  logic                        pend_vld_q, pend_vld_d;
  logic [6:0]                  sseg_q, sseg_d;
  logic                        dp_q, dp_d;
  logic [NUM_DIGITS-1:0]       an_q, an_d;
  logic                        fd_q, fd_d;

  logic                        tick, wrap, commit, lit;
  logic [NUM_DIGITS-1:0]       onehot, lz_blank;
  logic [NUM_DIGITS-1:0][3:0]  nibs;

  assign nibs = disp_val_q;

  // Leading-zero mask: digit i blanks when it and everything above it is 0 and no dp
  always_comb begin
    lz_blank = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      lz_blank[i] = (BLANK_LZ != 0) && ((disp_val_q >> (4 * i)) == '0) && !disp_dp_q[i];
  end

  // Next-state: prescaler, scan index, image double buffer, output decode
  always_comb begin
    tick    = (presc_q == PMAX);
    wrap    = tick && (idx_q == IMAX);
    commit  = wrap && (pend_vld_q || load);

    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == IMAX) ? '0 : idx_q + 1'b1;

    // Last load wins; a load on the commit cycle feeds straight through
    pend_val_d = load ? value    : pend_val_q;
    pend_dp_d  = load ? dp_in    : pend_dp_q;
    pend_en_d  = load ? digit_en : pend_en_q;
    pend_vld_d = commit ? 1'b0 : (load ? 1'b1 : pend_vld_q);

    disp_val_d = commit ? pend_val_d : disp_val_q;
    disp_dp_d  = commit ? pend_dp_d  : disp_dp_q;
    disp_en_d  = commit ? pend_en_d  : disp_en_q;
    fd_d       = commit;

    onehot = '0;
    onehot[idx_q] = 1'b1;
    lit    = 1'b0;
    sseg_d = sseg_q;
    dp_d   = dp_q;
    an_d   = an_q;
    if (tick) begin
      an_d = AL ? ~onehot : onehot;
      if (!disp_en_q[idx_q] || lz_blank[idx_q]) begin
        sseg_d = SEG_OFF;
      end else begin
        sseg_d = AL ? hex7(nibs[idx_q]) : ~hex7(nibs[idx_q]);
        lit    = disp_dp_q[idx_q];
      end
      dp_d = AL ? ~lit : lit;
    end
  end

  // State registers; the reset image has all digits enabled so it reads as "0"
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_en_q  <= '1;
      pend_vld_q <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      disp_en_q  <= '1;
      sseg_q     <= SEG_OFF;
      dp_q       <= AL;
      an_q       <= AN_OFF;
      fd_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_en_q  <= pend_en_d;
      pend_vld_q <= pend_vld_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      disp_en_q  <= disp_en_d;
      sseg_q     <= sseg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign sseg       = sseg_q;
  assign dp_out     = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: three configurations share one stimulus stream
// and are checked every cycle against a cycle-count/arithmetic reference model.
module tb_sseg_scan_driver;
  localparam int ND = 4;
  localparam int NI = 3;

  logic        clock = 1'b0;
  logic        reset_n, load;
  logic [15:0] value;
  logic [3:0]  dp_in, digit_en;

  logic [6:0]  sseg_o [NI];
  logic        dp_o   [NI];
  logic [3:0]  an_o   [NI];
  logic        fd_o   [NI];

  always #5 clock = ~clock;

  sseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1), .ACTIVE_LOW(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .load(load), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .sseg(sseg_o[0]), .dp_out(dp_o[0]), .an(an_o[0]), .frame_done(fd_o[0]));
  sseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(0), .ACTIVE_LOW(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .load(load), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .sseg(sseg_o[1]), .dp_out(dp_o[1]), .an(an_o[1]), .frame_done(fd_o[1]));
  sseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(1), .BLANK_LZ(1), .ACTIVE_LOW(0)) dut_c (
    .clock(clock), .reset_n(reset_n), .load(load), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .sseg(sseg_o[2]), .dp_out(dp_o[2]), .an(an_o[2]), .frame_done(fd_o[2]));

  // Reference model configuration and state
  int cfg_r  [NI] = '{4, 4, 1};
  int cfg_lz [NI] = '{1, 0, 1};
  int cfg_al [NI] = '{1, 1, 0};
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          m_cyc  [NI];
  logic [15:0] m_pv   [NI], m_dv [NI];
  logic [3:0]  m_pd   [NI], m_pe [NI], m_dd [NI], m_de [NI];
  bit          m_pvld [NI];
  logic [6:0]  exp_seg [NI];
  logic        exp_dp  [NI];
  logic [3:0]  exp_an  [NI];
  logic        exp_fd  [NI];

  int vectors = 0;
  int miscompares = 0;

  task automatic m_reset();
    for (int k = 0; k < NI; k++) begin
      m_cyc[k] = 0;  m_pvld[k] = 1'b0;
      m_pv[k] = '0;  m_pd[k] = '0;  m_pe[k] = 4'hF;
      m_dv[k] = '0;  m_dd[k] = '0;  m_de[k] = 4'hF;
      exp_seg[k] = (cfg_al[k] != 0) ? 7'h7F : 7'h00;
      exp_dp[k]  = (cfg_al[k] != 0);
      exp_an[k]  = (cfg_al[k] != 0) ? 4'hF : 4'h0;
      exp_fd[k]  = 1'b0;
    end
  endtask

  // One rising edge of the model: tick number = cyc / R, lit digit = tick number mod ND
  task automatic m_clock(input bit ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    for (int k = 0; k < NI; k++) begin
      int r, dig;
      bit wrap, blank, lit;
      logic [6:0] seg;
      r = cfg_r[k];
      wrap = 1'b0;
      if ((m_cyc[k] % r) == r - 1) begin
        dig = (m_cyc[k] / r) % ND;
        wrap = (dig == ND - 1);
        blank = !m_de[k][dig] ||
                (cfg_lz[k] != 0 && dig > 0 && (m_dv[k] >> (4 * dig)) == 0 && !m_dd[k][dig]);
        seg = blank ? 7'h7F : seg_tab[4'((m_dv[k] >> (4 * dig)) & 16'hF)];
        lit = !blank && m_dd[k][dig];
        exp_seg[k] = (cfg_al[k] != 0) ? seg : ~seg;
        exp_dp[k]  = (cfg_al[k] != 0) ? !lit : lit;
        exp_an[k]  = (cfg_al[k] != 0) ? ~4'(1 << dig) : 4'(1 << dig);
      end
      exp_fd[k] = 1'b0;
      if (ld) begin m_pv[k] = v; m_pd[k] = d; m_pe[k] = e; end
      if (wrap && (m_pvld[k] || ld)) begin
        m_dv[k] = m_pv[k];  m_dd[k] = m_pd[k];  m_de[k] = m_pe[k];
        m_pvld[k] = 1'b0;
        exp_fd[k] = 1'b1;
      end else if (ld) begin
        m_pvld[k] = 1'b1;
      end
      m_cyc[k]++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s[%0d].sseg", tag, k), 32'(sseg_o[k]), 32'(exp_seg[k]));
      chk($sformatf("%s[%0d].dp", tag, k), 32'(dp_o[k]), 32'(exp_dp[k]));
      chk($sformatf("%s[%0d].an", tag, k), 32'(an_o[k]), 32'(exp_an[k]));
      chk($sformatf("%s[%0d].fd", tag, k), 32'(fd_o[k]), 32'(exp_fd[k]));
    end
  endtask

  task automatic step(input string tag, input bit ld, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] e);
    load = ld; value = v; dp_in = d; digit_en = e;
    @(posedge clock);
    if (reset_n) m_clock(ld, v, d, e); else m_reset();
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    repeat (n) step(tag, 1'b0, value, dp_in, digit_en);
  endtask

  // Idle until dut_a's model sits at a given cycle within its 16-cycle frame
  task automatic to_phase(input string tag, input int ph);
    for (int i = 0; i < 16 && (m_cyc[0] % 16) != ph; i++) idle(tag, 1);
    chk({tag, ".phase"}, 32'(m_cyc[0] % 16), 32'(ph));
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; digit_en = '0;
    m_reset();
    idle("rst", 3);
    reset_n = 1'b1;
    idle("idle", 40);

    // Mid-frame load, shown from the next frame only
    to_phase("mid", 6);
    step("mid_ld", 1'b1, 16'h12AF, 4'b0100, 4'b1111);
    idle("mid", 40);

    // Two loads in one frame: last wins, one frame_done
    to_phase("two", 2);
    step("two_ld1", 1'b1, 16'h1111, 4'b0000, 4'b1111);
    idle("two", 3);
    step("two_ld2", 1'b1, 16'h2222, 4'b0000, 4'b1111);
    idle("two", 36);

    // Load on the wrap cycle while pending is valid: load inputs win
    to_phase("coin", 8);
    step("coin_ld1", 1'b1, 16'h3333, 4'b0001, 4'b1111);
    to_phase("coin", 15);
    step("coin_ld2", 1'b1, 16'h4C5D, 4'b1000, 4'b1111);
    idle("coin", 36);

    // Enable mask and leading-zero blanking
    step("lz_ld", 1'b1, 16'h0005, 4'b0000, 4'b1011);
    idle("lz", 40);

    // Value 8, then asynchronous reset mid-scan
    step("v8_ld", 1'b1, 16'h0008, 4'b0000, 4'b1111);
    idle("v8", 30);
    #2 reset_n = 1'b0;
    #1 m_reset();
    check_all("async_rst");
    @(negedge clock);
    idle("in_rst", 2);
    reset_n = 1'b1;
    idle("post_rst", 24);

    // Randomized loads, values, dp and enables
    for (int i = 0; i < 800; i++) begin
      logic [3:0] en;
      en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 5) == 0)
        step("rnd", 1'b1, 16'($urandom) >> (4 * $urandom_range(0, 3)), 4'($urandom), en);
      else
        idle("rnd", 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
